mealy_state_seq: RTL and testbench
==================================

# mealy_state_seq

Sequential next-state stage that sits directly upstream of the Mealy output decoder and drives its 2-bit `state` input. It holds the current state of the four-state (A/B/C/D) Mealy machine and advances it on enabled cycles from the 1-bit input. It also exposes a forced-load path and transition bookkeeping: a change counter, sticky visited flags and an optional dwell watchdog. The downstream decoder combines `state` with the same-cycle `in` to form its 3-bit output.

## Interface
- `CNT_W`, default 8: width of the transition counter.
- `DWELL_MAX`, default 15: dwell watchdog threshold. Used only with `MEALY_SEQ_DWELL_EN`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  step enable; the FSM advances on `in` at the clock edge.
- `in`  in  1  Mealy input, also routed to the decoder.
- `load`  in  1  force `state` to `load_state`.
- `load_state`  in  2  forced state value.
- `clr`  in  1  clear `trans_cnt` and `visited`.
- `state`  out  2  current state to the decoder: A=00, B=01, C=10, D=11.
- `prev_state`  out  2  state held before the last register update.
- `changed`  out  1  the last enabled step changed `state`.
- `trans_cnt`  out  `CNT_W`  count of state-changing steps; wraps.
- `cnt_wrap`  out  1  one-cycle pulse when `trans_cnt` wraps to 0.
- `visited`  out  4  sticky one-hot flags of states entered (bit i = state i).
- `stuck`  out  1  dwell watchdog flag; tied 0 without the macro.

## Operation
- Transitions on `en & !load`:
  - A: `in=0` → B, `in=1` → A.
  - B: `in=0` → C, `in=1` → A.
  - C: `in=0` → D, `in=1` → B.
  - D: `in=0` → D, `in=1` → A.
- Priority: `reset_n`=0 beats `load`; `load` beats `en`. With `en=0` and no `load`, all state is held.
- Enabled step:
  - `prev_state` ← `state`, `state` ← next.
  - `changed` ← (next != `state`).
  - If next != `state`, `trans_cnt` increments modulo 2^`CNT_W`.
  - `visited[next]` is set.
- Load:
  - `prev_state` ← `state`, `state` ← `load_state`.
  - `changed` ← 0, `trans_cnt` unchanged.
  - `visited[load_state]` is set.
- `cnt_wrap`: 1 in the cycle after `trans_cnt` goes from all-ones to 0; otherwise 0.
- `clr`:
  - `trans_cnt` ← 0, or 1 if a state-changing step occurs in the same cycle.
  - `visited` ← one-hot of the post-edge `state`.
  - `clr` does not affect `state`, `prev_state` or `changed`.
- Reset values: `state`=00, `prev_state`=00, `changed`=0, `trans_cnt`=0, `cnt_wrap`=0, `visited`=0001, `stuck`=0. Dwell counter is 0.
- Reset mid-operation discards any in-flight `en`, `load` or `clr` in that cycle.

## Timing
- All outputs are registered.
- `state` updates one edge after `en` or `load` is sampled high.
- Decoder output is valid combinationally in the same cycle from `state` and the live `in`; this block adds no latency to that path.
- `changed` and `cnt_wrap` are valid in the cycle after the causing edge and last exactly one cycle unless re-triggered.
- Back-to-back `en` is legal on every cycle; throughput is one step per clock.

## Configuration
- `MEALY_SEQ_DWELL_EN` defined:
  - A dwell counter counts clocks since the `state` register last changed value, regardless of `en`.
  - The counter resets to 0 on any value change, on `load`, and on reset.
  - It saturates at `DWELL_MAX`.
  - `stuck` = 1 while the counter equals `DWELL_MAX`.
- Not defined: no dwell counter is synthesised and `stuck` is constant 0.

## Structure
- Package `mealy_pkg` holds:
  - `state_t` enum (A, B, C, D with the encodings above).
  - Function `mealy_next(state_t, logic in)`.
  - Constant `MEALY_RESET_STATE` = A.
- The decoder and its testbench also import `mealy_pkg`.
- Sub-module `mealy_dwell_counter` holds the saturating watchdog and is instantiated only under `MEALY_SEQ_DWELL_EN`.

## Test plan
- Reset, then `en=1` with `in`=0,0,0 → `state` B,C,D; `trans_cnt`=3; `visited`=1111; `changed`=1 each cycle.
- In D, `en=1` with `in=0` → `state` stays 11; `changed`=0; `trans_cnt` unchanged. Then `in=1` → `state`=00; `prev_state`=11.
- `load=1`, `load_state`=10 together with `en=1`, `in=1` → `state`=10 (load wins); `changed`=0; `trans_cnt` unchanged.
- `CNT_W`=8, 256 state-changing steps (alternate A/B) → `trans_cnt`=0 and `cnt_wrap`=1 for exactly one cycle.
- `clr=1` with a step from A on `in=0` → `trans_cnt`=1; `visited`=0010.
- `reset_n`=0 during a stream → all outputs at reset values next cycle. With the macro and `DWELL_MAX`=15, 15 idle cycles → `stuck`=1; first `state` change → `stuck`=0.

Source files
------------

// File: rtl/mealy_pkg.sv
// mealy_pkg: shared state encoding and next-state rule for the A/B/C/D Mealy machine.
package mealy_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_D = 2'b11
    } state_t;

    localparam state_t MEALY_RESET_STATE = ST_A;

    function automatic state_t mealy_next(state_t s, logic in);
        if (in)
            return (s == ST_C) ? ST_B : ST_A;
        return (s == ST_A) ? ST_B : (s == ST_B) ? ST_C : ST_D;
    endfunction

endpackage

// File: rtl/mealy_dwell_counter.sv
// mealy_dwell_counter: saturating count of clocks since the watched state last changed.
module mealy_dwell_counter #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic stuck
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = restart ? '0 : (cnt_q == W'(MAX)) ? cnt_q : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stuck = (cnt_q == W'(MAX));

endmodule

// File: rtl/mealy_state_seq.sv
// mealy_state_seq: state register of the A/B/C/D Mealy machine with load, change counter and visited flags.
// Define MEALY_SEQ_DWELL_EN to build the dwell watchdog behind `stuck`.
module mealy_state_seq
    import mealy_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DWELL_MAX = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in,
    input  logic             load,
    input  logic [1:0]       load_state,
    input  logic             clr,
    output logic [1:0]       state,
    output logic [1:0]       prev_state,
    output logic             changed,
    output logic [CNT_W-1:0] trans_cnt,
    output logic             cnt_wrap,
    output logic [3:0]       visited,
    output logic             stuck
);
    state_t           state_q, state_d, prev_q, prev_d, nxt;
    logic             changed_q, changed_d, wrap_q, wrap_d, step, inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       vis_q, vis_d;

    always_comb begin
        nxt       = mealy_next(state_q, in);
        step      = en & ~load;
        inc       = step & (nxt != state_q);
        state_d   = load ? state_t'(load_state) : step ? nxt : state_q;
        prev_d    = (load | en) ? state_q : prev_q;
        changed_d = inc;
        cnt_d     = clr ? CNT_W'(inc) : cnt_q + CNT_W'(inc);
        wrap_d    = inc & ~clr & (&cnt_q);
        // The current state is always a member of visited, so clr can simply rebuild from it.
        vis_d     = (clr ? 4'b0000 : vis_q) | (4'b0001 << state_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= MEALY_RESET_STATE;
            prev_q    <= MEALY_RESET_STATE;
            changed_q <= 1'b0;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            vis_q     <= 4'b0001;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            vis_q     <= vis_d;
        end
    end

    assign state      = state_q;
    assign prev_state = prev_q;
    assign changed    = changed_q;
    assign trans_cnt  = cnt_q;
    assign cnt_wrap   = wrap_q;
    assign visited    = vis_q;

`ifdef MEALY_SEQ_DWELL_EN
    logic dwell_restart;

    assign dwell_restart = load | (state_d != state_q);

    mealy_dwell_counter #(.MAX(DWELL_MAX)) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (dwell_restart),
        .stuck   (stuck)
    );
`else
    logic unused_dwell_max;

    assign unused_dwell_max = ^DWELL_MAX;
    assign stuck            = 1'b0;
`endif

endmodule

// File: tb/tb_mealy_state_seq.sv
// tb_mealy_state_seq: directed table, wrap/reset/dwell sequences and randomized run against a table-based model.
module tb_mealy_state_seq;
    import mealy_pkg::*;

`ifdef MEALY_SEQ_DWELL_EN
    localparam bit DW = 1'b1;
`else
    localparam bit DW = 1'b0;
`endif

    logic       clk = 0, reset_n = 0, en = 0, in_s = 0, load = 0, clr = 0;
    logic [1:0] load_state = 0;
    logic [1:0] state, prev_state;
    logic       changed, cnt_wrap, stuck;
    logic [7:0] trans_cnt;
    logic [3:0] visited;

    int errors = 0, checks = 0;
    int m_st, m_pv, m_ch, m_cnt, m_wrap, m_vis, m_dw;
    int next_tab[4][2] = '{'{1, 0}, '{2, 0}, '{3, 1}, '{3, 0}};

    typedef struct {
        bit en; bit in; bit ld; bit [1:0] ls; bit clr;
        int st; int pv; int ch; int cnt; int vis;
    } vec_t;
    vec_t vt[11];

    mealy_state_seq #(.CNT_W(8), .DWELL_MAX(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .in         (in_s),
        .load       (load),
        .load_state (load_state),
        .clr        (clr),
        .state      (state),
        .prev_state (prev_state),
        .changed    (changed),
        .trans_cnt  (trans_cnt),
        .cnt_wrap   (cnt_wrap),
        .visited    (visited),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, and sample just after the edge.
    task automatic cyc(input bit rn, input bit e, input bit i, input bit ld, input bit [1:0] ls, input bit c);
        int old, nx;
        bit mv;
        reset_n = rn; en = e; in_s = i; load = ld; load_state = ls; clr = c;
        old = m_st;
        if (!rn) begin
            m_st = 0; m_pv = 0; m_ch = 0; m_cnt = 0; m_wrap = 0; m_vis = 1;
        end else begin
            nx = ld ? int'(ls) : e ? next_tab[m_st][i] : m_st;
            mv = !ld && e && nx != m_st;
            if (ld || e) m_pv = m_st;
            m_ch = mv;
            m_wrap = mv && !c && m_cnt == 255;
            m_cnt = c ? int'(mv) : (m_cnt + int'(mv)) % 256;
            m_st = nx;
            m_vis = (c ? 0 : m_vis) | (1 << m_st);
        end
        m_dw = (!rn || ld || m_st != old) ? 0 : (m_dw < 15 ? m_dw + 1 : 15);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " state"}, state, 0);
        chk({tag, " prev"}, prev_state, 0);
        chk({tag, " changed"}, changed, 0);
        chk({tag, " cnt"}, trans_cnt, 0);
        chk({tag, " wrap"}, cnt_wrap, 0);
        chk({tag, " visited"}, visited, 1);
        chk({tag, " stuck"}, stuck, 0);
    endtask

    function automatic vec_t mk(bit e, bit i, bit ld, bit [1:0] ls, bit c, int st, int pv, int ch, int cnt, int vis);
        mk = '{e, i, ld, ls, c, st, pv, ch, cnt, vis};
    endfunction

    initial begin
        int wrap_seen;
        vt[0]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 4'b0011);
        vt[1]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 2, 4'b0111);
        vt[2]  = mk(1, 0, 0, 0, 0, 3, 2, 1, 3, 4'b1111);
        vt[3]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 3, 4'b1111);
        vt[4]  = mk(1, 1, 0, 0, 0, 0, 3, 1, 4, 4'b1111);
        vt[5]  = mk(1, 1, 1, 2, 0, 2, 0, 0, 4, 4'b1111);
        vt[6]  = mk(0, 0, 0, 0, 0, 2, 0, 0, 4, 4'b1111);
        vt[7]  = mk(1, 1, 0, 0, 0, 1, 2, 1, 5, 4'b1111);
        vt[8]  = mk(0, 0, 0, 0, 1, 1, 2, 0, 0, 4'b0010);
        vt[9]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 4'b0011);
        vt[10] = mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 4'b0010);

        cyc(0, 0, 0, 0, 0, 0);
        chk_reset("reset");

        for (int k = 0; k < 11; k++) begin
            cyc(1, vt[k].en, vt[k].in, vt[k].ld, vt[k].ls, vt[k].clr);
            chk($sformatf("vec%0d state", k), state, vt[k].st);
            chk($sformatf("vec%0d prev", k), prev_state, vt[k].pv);
            chk($sformatf("vec%0d changed", k), changed, vt[k].ch);
            chk($sformatf("vec%0d cnt", k), trans_cnt, vt[k].cnt);
            chk($sformatf("vec%0d visited", k), visited, vt[k].vis);
        end

        cyc(0, 1, 1, 1, 2'b11, 1);
        chk_reset("midreset");

        wrap_seen = 0;
        for (int k = 0; k < 255; k++) begin
            cyc(1, 1, k[0], 0, 0, 0);
            if (cnt_wrap) wrap_seen++;
        end
        chk("wrap pre cnt", trans_cnt, 255);
        chk("wrap pre pulses", wrap_seen, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("wrap cnt", trans_cnt, 0);
        chk("wrap pulse", cnt_wrap, 1);
        chk("wrap state", state, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("wrap pulse end", cnt_wrap, 0);
        chk("wrap hold cnt", trans_cnt, 0);

        cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) cyc(1, 0, 0, 0, 0, 0);
        chk("dwell 14", stuck, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("dwell 15", stuck, DW);
        cyc(1, 1, 1, 0, 0, 0);
        chk("dwell self-loop", stuck, DW);
        cyc(1, 1, 0, 0, 0, 0);
        chk("dwell change", stuck, 0);

        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
            chk("rnd state", state, m_st);
            chk("rnd prev", prev_state, m_pv);
            chk("rnd changed", changed, m_ch);
            chk("rnd cnt", trans_cnt, m_cnt);
            chk("rnd wrap", cnt_wrap, m_wrap);
            chk("rnd visited", visited, m_vis);
            chk("rnd stuck", stuck, DW ? int'(m_dw == 15) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
